morse_key_ctrl: RTL and testbench
=================================

MORSE_KEY_CTRL -- requirements
Module: morse_key_ctrl

Interface
REQ-001 Parameter MIN_PRESS, default 2: presses shorter than this many cycles are glitches and are ignored.
REQ-002 Parameter DASH_MIN, default 8: press length in cycles at or above which an element is a dash; shorter is a dot.
REQ-003 Parameter GAP_CYCLES, default 16: idle cycles after a release that end a letter.
REQ-004 Parameter FIFO_DEPTH, default 4: symbol queue depth, power of two.
REQ-005 Clock  in  1  clock; all logic on posedge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 key  in  1  raw key level, asynchronous; 1 = pressed.
REQ-008 symbol_in  in  6  decoder state code; 0-35 = digit/letter, 36 = DECODING (nothing entered), 37-39 = intermediate.
REQ-009 dot  out  1  one-cycle pulse to the decoder.
REQ-010 dash  out  1  one-cycle pulse to the decoder.
REQ-011 dec_reset  out  1  one-cycle clear to the decoder.
REQ-012 sym_valid  out  1  queue head valid.
REQ-013 sym_data  out  6  queue head symbol code.
REQ-014 sym_ready  in  1  consumer accepts the head when sym_valid & sym_ready.
REQ-015 sym_err  out  1  one-cycle pulse: letter committed with an invalid code.
REQ-016 overflow  out  1  sticky: a symbol was dropped because the queue was full.

Function
REQ-017 key passes through a 2-flop synchronizer; all timing is counted on the synchronized level (ks).
REQ-018 FSM states: IDLE, PRESS, GAP, COMMIT, CLEAR.
REQ-019 IDLE: ks=1 goes to PRESS with the press counter set to 1.
REQ-020 PRESS: the counter increments each cycle while ks=1 and saturates at DASH_MIN.
REQ-021 PRESS, ks falls with count < MIN_PRESS: no pulse; return to GAP if elements > 0, else IDLE.
REQ-022 PRESS, ks falls with count >= MIN_PRESS: on the next cycle pulse dot (count < DASH_MIN) or dash (count >= DASH_MIN), increment the element count, enter GAP, and clear the gap counter.
REQ-023 dot and dash are never high together and are never high in consecutive cycles.
REQ-024 Sixth element: no pulse is issued, the letter is marked bad, and it is still committed.
REQ-025 GAP: the gap counter increments while ks=0.
REQ-026 GAP, ks=1 before the counter reaches GAP_CYCLES: go to PRESS.
REQ-027 GAP, counter reaches GAP_CYCLES: go to COMMIT.
REQ-028 COMMIT (one cycle): sample symbol_in.
REQ-029 COMMIT, code <= 35 and letter not bad: push the code.
REQ-030 COMMIT, otherwise: pulse sym_err and push nothing.
REQ-031 COMMIT with the queue full, and no simultaneous pop: drop the symbol and set overflow.
REQ-032 CLEAR (one cycle): assert dec_reset, clear the element count and bad flag, go to IDLE.
REQ-033 A key press during COMMIT or CLEAR is seen in IDLE; no element is lost.
REQ-034 Queue: first-in first-out order, with sym_data valid whenever sym_valid=1.
REQ-035 Push and pop in the same cycle: both happen, including when the queue is full; pop while empty is ignored.
REQ-036 Latency: symbol visible on sym_valid 1 cycle after COMMIT.

Reset
REQ-037 Reset puts the FSM in CLEAR, so dec_reset pulses in the first cycle after reset.
REQ-038 Reset clears all counters, the synchronizer and the queue.
REQ-039 Outputs during reset: dot=dash=sym_valid=sym_err=overflow=0.
REQ-040 Reset mid-press or mid-gap discards the partial letter; an element is not emitted later.

Structure
REQ-041 Package morse_pkg holds: the 6-bit symbol codes 0-39, constants DECODING=36 and MAX_VALID=35, and the FSM state enum.
REQ-042 The queue is sub-module morse_sym_fifo (parameter DEPTH; push, pop, full, empty); no other sub-modules.

Verification
REQ-043 Press 4 cycles, idle -> one dot pulse; decoder gives 14; sym_data=14 (E), sym_valid=1, dec_reset pulse.
REQ-044 Press 10 cycles, idle -> one dash pulse, sym_data=29 (T).
REQ-045 Five dash presses separated by 6-cycle gaps -> five dash pulses, one push of 0 after the final gap; six dashes -> five pulses, sym_err, no push.
REQ-046 1-cycle key glitch in IDLE -> no pulse, no push, no dec_reset.
REQ-047 Five letters with sym_ready=0 -> four queued in order, overflow=1; then sym_ready=1 drains four codes.
REQ-048 Reset asserted in mid-PRESS of a dash -> no dash pulse, dec_reset pulses after reset, queue empty.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key controller.
// Symbol codes: 0-35 digit/letter, 36 DECODING, 37-39 intermediate.
package morse_pkg;

    typedef logic [5:0] sym_t;

    localparam sym_t MAX_VALID = 6'd35;
    localparam sym_t DECODING  = 6'd36;
    localparam sym_t SYM_LAST  = 6'd39;

    localparam logic [2:0] MAX_ELEMS = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_COMMIT,
        ST_CLEAR
    } state_t;

    function automatic logic sym_ok(input sym_t code);
        return code <= MAX_VALID;
    endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Symbol queue between the key controller and its consumer.
// Push and pop in the same cycle both take effect, even when full.
module morse_sym_fifo
    import morse_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic push,
    input  logic pop,
    input  sym_t wdata,
    output sym_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    sym_t          r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign full  = (r_cnt == FULL_CNT);
    assign empty = (r_cnt == '0);
    assign w_wr  = push && (!full || pop);
    assign w_rd  = pop && !empty;
    assign rdata = r_mem[r_rp];

    always_ff @(posedge Clock) begin
        if (w_wr)
            r_mem[r_wp] <= wdata;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_rd)
                r_rp <= r_rp + 1'b1;
            if (w_wr && !w_rd)
                r_cnt <= r_cnt + 1'b1;
            else if (w_rd && !w_wr)
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/morse_key_ctrl.sv
// Morse key front end: times key presses into dot/dash pulses,
// commits the decoder result after a letter gap and queues it.
module morse_key_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned MIN_PRESS  = 2,
    parameter int unsigned DASH_MIN   = 8,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic key,
    input  sym_t symbol_in,
    output logic dot,
    output logic dash,
    output logic dec_reset,
    output logic sym_valid,
    output sym_t sym_data,
    input  logic sym_ready,
    output logic sym_err,
    output logic overflow
);

    localparam int unsigned CW = $clog2(DASH_MIN + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    state_t        r_state;
    logic          r_k1;
    logic          r_ks;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic [2:0]    r_elems;
    logic          r_bad;
    logic          r_dot;
    logic          r_dash;
    logic          r_err;
    logic          r_ovf;

    logic          w_good;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;

    assign w_good = sym_ok(symbol_in) && !r_bad;
    assign w_push = (r_state == ST_COMMIT) && w_good;
    assign w_pop  = sym_ready && !w_empty;

    assign dot       = r_dot;
    assign dash      = r_dash;
    assign sym_err   = r_err;
    assign overflow  = r_ovf;
    assign dec_reset = (r_state == ST_CLEAR);
    assign sym_valid = !w_empty;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_CLEAR;
            r_k1    <= 1'b0;
            r_ks    <= 1'b0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_elems <= '0;
            r_bad   <= 1'b0;
            r_dot   <= 1'b0;
            r_dash  <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_k1   <= key;
            r_ks   <= r_k1;
            r_dot  <= 1'b0;
            r_dash <= 1'b0;
            r_err  <= 1'b0;
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (r_ks) begin
                        r_state <= ST_PRESS;
                        r_cnt   <= CW'(1);
                    end
                end
                ST_PRESS: begin
                    if (r_ks) begin
                        if (r_cnt != CW'(DASH_MIN))
                            r_cnt <= r_cnt + 1'b1;
                    end else if (r_cnt < CW'(MIN_PRESS)) begin
                        r_state <= (r_elems != '0) ? ST_GAP : ST_IDLE;
                    end else begin
                        r_state <= ST_GAP;
                        r_gap   <= '0;
                        // A sixth element is swallowed; the letter is spoiled.
                        if (r_elems == MAX_ELEMS) begin
                            r_bad <= 1'b1;
                        end else begin
                            r_elems <= r_elems + 1'b1;
                            r_dash  <= (r_cnt >= CW'(DASH_MIN));
                            r_dot   <= (r_cnt < CW'(DASH_MIN));
                        end
                    end
                end
                ST_GAP: begin
                    if (r_ks) begin
                        r_state <= ST_PRESS;
                        r_cnt   <= CW'(1);
                    end else if (r_gap == GW'(GAP_CYCLES - 1)) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_err   <= !w_good;
                    r_state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_elems <= '0;
                    r_bad   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_CLEAR;
            endcase
        end
    end

    morse_sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (w_push),
        .pop   (sym_ready),
        .wdata (symbol_in),
        .rdata (sym_data),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

// File: tb/tb_morse_key_ctrl.sv
// Bench for morse_key_ctrl: directed key sequences, a small decoder
// model, and a scoreboard queue checked by an independent monitor.
module tb_morse_key_ctrl;

    logic       Clock;
    logic       Reset;
    logic       key;
    logic [5:0] symbol_in;
    logic       dot;
    logic       dash;
    logic       dec_reset;
    logic       sym_valid;
    logic [5:0] sym_data;
    logic       sym_ready;
    logic       sym_err;
    logic       overflow;

    morse_key_ctrl dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .key       (key),
        .symbol_in (symbol_in),
        .dot       (dot),
        .dash      (dash),
        .dec_reset (dec_reset),
        .sym_valid (sym_valid),
        .sym_data  (sym_data),
        .sym_ready (sym_ready),
        .sym_err   (sym_err),
        .overflow  (overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_pass = 0;
    int n_dot = 0;
    int n_dash = 0;
    int n_err = 0;
    int n_dec = 0;
    bit prev_pulse = 1'b0;
    int expq[$];

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s got %0d want %0d", name, got, exp);
    endtask

    // Decoder model: records elements, maps a few patterns to codes.
    logic [2:0] d_len;
    logic [4:0] d_pat;

    always @(posedge Clock) begin
        if (Reset || dec_reset) begin
            d_len <= 3'd0;
            d_pat <= 5'd0;
        end else if (dot || dash) begin
            d_len <= d_len + 3'd1;
            d_pat <= {d_pat[3:0], dash};
        end
    end

    function automatic logic [5:0] decode(input logic [2:0] len,
                                          input logic [4:0] pat);
        if (len == 3'd0) return 6'd36;
        if (len == 3'd1) return pat[0] ? 6'd29 : 6'd14;
        if (len == 3'd2) begin
            case (pat[1:0])
                2'b00: return 6'd18;
                2'b01: return 6'd10;
                2'b11: return 6'd22;
                default: return 6'd23;
            endcase
        end
        if (len == 3'd5 && pat == 5'b11111) return 6'd0;
        if (len == 3'd5 && pat == 5'b00000) return 6'd5;
        return 6'd37;
    endfunction

    always_comb symbol_in = decode(d_len, d_pat);

    // Monitor: pulse accounting and scoreboard pops.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (dot) n_dot++;
            if (dash) n_dash++;
            if (sym_err) n_err++;
            if (dec_reset) n_dec++;
            if (dot || dash)
                check("pulse_excl", int'({dot & dash, prev_pulse}), 0);
            prev_pulse = dot || dash;
            if (sym_valid && sym_ready) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_sym got %0d want none",
                             sym_data);
                end else begin
                    check("sym_data", int'(sym_data), expq.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic press(input int hi, input int lo);
        key = 1'b1;
        tick(hi);
        key = 1'b0;
        tick(lo);
    endtask

    task automatic letter(input string code);
        for (int i = 0; i < code.len(); i++)
            press((code[i] == "-") ? 10 : 4, 6);
        tick(20);
    endtask

    int s_dot, s_dash, s_err, s_dec, lat;

    task automatic snap();
        s_dot  = n_dot;
        s_dash = n_dash;
        s_err  = n_err;
        s_dec  = n_dec;
    endtask

    initial begin
        Reset     = 1'b1;
        key       = 1'b0;
        sym_ready = 1'b1;
        tick(3);
        @(negedge Clock);
        check("rst_outs", int'({dot, dash, sym_valid, sym_err, overflow}), 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("rst_dec_reset", int'(dec_reset), 1);
        @(negedge Clock);
        check("rst_dec_after", int'(dec_reset), 0);
        tick(2);

        // E: single dot, with latency from key release to sym_valid.
        snap();
        expq.push_back(14);
        key = 1'b1;
        tick(4);
        key = 1'b0;
        lat = 60;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clock);
            if (sym_valid) begin
                lat = k;
                break;
            end
        end
        check("e_latency", lat, 20);
        tick(10);
        check("e_dots", n_dot - s_dot, 1);
        check("e_dashes", n_dash - s_dash, 0);
        check("e_dec", n_dec - s_dec, 1);
        check("e_drained", expq.size(), 0);

        // T: single dash.
        snap();
        expq.push_back(29);
        letter("-");
        check("t_dashes", n_dash - s_dash, 1);
        check("t_dots", n_dot - s_dot, 0);
        check("t_drained", expq.size(), 0);

        // Five dashes -> digit 0.
        snap();
        expq.push_back(0);
        letter("-----");
        check("d0_dashes", n_dash - s_dash, 5);
        check("d0_err", n_err - s_err, 0);
        check("d0_drained", expq.size(), 0);

        // Six dashes -> five pulses, error, nothing queued.
        snap();
        letter("------");
        check("six_dashes", n_dash - s_dash, 5);
        check("six_err", n_err - s_err, 1);
        check("six_dec", n_dec - s_dec, 1);
        check("six_valid", int'(sym_valid), 0);

        // One-cycle glitch in IDLE.
        snap();
        press(1, 30);
        check("gl_pulses", (n_dot - s_dot) + (n_dash - s_dash), 0);
        check("gl_dec", n_dec - s_dec, 0);
        check("gl_valid", int'(sym_valid), 0);

        // Five letters with consumer stalled: four kept, overflow set.
        sym_ready = 1'b0;
        expq.push_back(14);
        expq.push_back(29);
        expq.push_back(10);
        expq.push_back(22);
        letter(".");
        letter("-");
        letter(".-");
        letter("--");
        check("ov_before", int'(overflow), 0);
        letter("-.");
        check("ov_set", int'(overflow), 1);
        check("ov_valid", int'(sym_valid), 1);
        check("ov_head", int'(sym_data), 14);
        sym_ready = 1'b1;
        tick(10);
        check("ov_drained", expq.size(), 0);
        check("ov_empty", int'(sym_valid), 0);
        check("ov_sticky", int'(overflow), 1);

        // Reset in the middle of a dash press.
        snap();
        key = 1'b1;
        tick(12);
        Reset = 1'b1;
        key   = 1'b0;
        tick(2);
        @(negedge Clock);
        check("mr_outs", int'({dot, dash, sym_valid, sym_err, overflow}), 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("mr_dec_reset", int'(dec_reset), 1);
        tick(30);
        check("mr_dash", n_dash - s_dash, 0);
        check("mr_valid", int'(sym_valid), 0);
        check("mr_queue", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
